// File: rtl/pcie_dll_acknak_scheduler_pkg.sv
// Shared types for the DLL Ack/Nak scheduler: DLLP payload layout, DLLP type codes
// and scheduler states.
package pcie_dll_acknak_scheduler_pkg;

  localparam int unsigned SEQ_W = 12;
  localparam int unsigned CRC_W = 16;

  localparam logic [7:0] DLLP_ACK = 8'h00;
  localparam logic [7:0] DLLP_NAK = 8'h10;

  // Ack/Nak DLLP: type byte, reserved bits, sequence number, then CRC
  typedef struct packed {
    logic [7:0]       ack_or_nak;
    logic [11:0]      reserved;
    logic [SEQ_W-1:0] seq_num;
    logic [CRC_W-1:0] crc16;
  } dllp_packet;

  localparam int unsigned PCIe_DLLP_PACKET_SIZE = $bits(dllp_packet);

  typedef enum logic [1:0] {
    IDLE,
    SEND_ACK,
    SEND_NAK
  } acknak_state_e;

endpackage

// File: rtl/pcie_dll_acknak_scheduler_if.sv
// DLLP handoff from the Ack/Nak scheduler to the DLL TX arbiter (valid/ready).
interface pcie_dll_acknak_scheduler_if;
  import pcie_dll_acknak_scheduler_pkg::*;

  logic       dllp_valid_o;
  dllp_packet dllp_o;
  logic       dllp_ready_i;

  modport master (output dllp_valid_o, output dllp_o, input dllp_ready_i);
  modport slave  (input dllp_valid_o, input dllp_o, output dllp_ready_i);
endinterface

// File: rtl/pcie_dll_acknak_scheduler_crc16.sv
// Combinational DLLP CRC-16 (poly 0x100B, init 0xFFFF, inverted result) over 32 bits,
// MSB first. Only built when DLLP_CRC16_EN is defined.
`ifdef DLLP_CRC16_EN
module pcie_dllp_crc16 (
  input  logic [31:0] data,
  output logic [15:0] crc
);
  logic [15:0] c;

  always_comb begin
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
      else                 c = {c[14:0], 1'b0};
    end
    crc = ~c;
  end
endmodule
`endif

// File: rtl/pcie_dll_acknak_scheduler.sv
// Ack/Nak DLLP scheduler: coalesces good-TLP Acks, issues one Nak per error episode,
// and holds each DLLP under valid/ready. DLLP_CRC16_EN fills in the DLLP CRC locally.
module pcie_dll_acknak_scheduler
  import pcie_dll_acknak_scheduler_pkg::*;
#(
  parameter logic [15:0]  ACK_LATENCY  = 16'd255,
  parameter logic [7:0]   ACK_COALESCE = 8'd4,
  parameter int unsigned  TIMER_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          evt_valid_i,
  input  logic                          evt_nak_i,
  input  logic [SEQ_W-1:0]              evt_seq_i,
  pcie_dll_acknak_scheduler_if.master   tx,
  output logic                          nak_scheduled_o,
  output logic                          ack_pending_o
);

  acknak_state_e      state;
  logic [SEQ_W-1:0]   last_seq;
  logic [7:0]         pend_cnt;
  logic [TIMER_W-1:0] timer;
  logic               ack_pending;
  logic               nak_scheduled;
  logic               nak_req;
  logic               dllp_valid;
  dllp_packet         dllp_q;

  logic               good_c;
  logic               bad_c;
  logic               ack_due_c;
  logic [7:0]         pend_inc_c;
  logic [CRC_W-1:0]   crc_c;
  dllp_packet         next_pkt_c;

  assign good_c     = evt_valid_i & ~evt_nak_i;
  assign bad_c      = evt_valid_i &  evt_nak_i;
  assign pend_inc_c = (pend_cnt == 8'hFF) ? pend_cnt : pend_cnt + 8'd1;
  assign ack_due_c  = ack_pending &&
                      ((timer >= TIMER_W'(ACK_LATENCY)) || (pend_cnt >= ACK_COALESCE));

`ifdef DLLP_CRC16_EN
  logic [31:0] crc_data_c;
  assign crc_data_c = {(nak_req ? DLLP_NAK : DLLP_ACK), 12'h000, last_seq};
  pcie_dllp_crc16 u_crc (.data(crc_data_c), .crc(crc_c));
`else
  assign crc_c = '0;
`endif

  // Packet captured on entry to SEND_*; Nak takes priority in IDLE
  always_comb begin
    next_pkt_c            = '0;
    next_pkt_c.ack_or_nak = nak_req ? DLLP_NAK : DLLP_ACK;
    next_pkt_c.seq_num    = last_seq;
    next_pkt_c.crc16      = crc_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_seq      <= '1;
      pend_cnt      <= '0;
      timer         <= '0;
      ack_pending   <= 1'b0;
      nak_scheduled <= 1'b0;
      nak_req       <= 1'b0;
      dllp_valid    <= 1'b0;
      dllp_q        <= '0;
    end else begin
      if (good_c) begin
        last_seq    <= evt_seq_i;
        ack_pending <= 1'b1;
        pend_cnt    <= pend_inc_c;
      end

      case (state)
        IDLE: begin
          if (ack_pending && (timer != '1)) timer <= timer + TIMER_W'(1);
          if (nak_req || ack_due_c) begin
            state      <= nak_req ? SEND_NAK : SEND_ACK;
            dllp_valid <= 1'b1;
            dllp_q     <= next_pkt_c;
            // pend_cnt now counts only TLPs newer than the captured seq_num
            if (!nak_req) pend_cnt <= good_c ? 8'd1 : 8'd0;
          end
        end
        SEND_ACK: begin
          if (tx.dllp_ready_i) begin
            state       <= IDLE;
            dllp_valid  <= 1'b0;
            timer       <= '0;
            ack_pending <= good_c || (pend_cnt != 8'd0);
          end
        end
        SEND_NAK: begin
          if (tx.dllp_ready_i) begin
            state      <= IDLE;
            dllp_valid <= 1'b0;
            nak_req    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // One Nak per episode; a good TLP closes the episode
      if (good_c) begin
        nak_scheduled <= 1'b0;
      end else if (bad_c && !nak_scheduled) begin
        nak_scheduled <= 1'b1;
        nak_req       <= 1'b1;
      end
    end
  end

  assign tx.dllp_valid_o = dllp_valid;
  assign tx.dllp_o       = dllp_q;
  assign nak_scheduled_o = nak_scheduled;
  assign ack_pending_o   = ack_pending;

endmodule

// File: tb/tb_pcie_dll_acknak_scheduler.sv
// Directed bench for the Ack/Nak scheduler: coalescing, latency, Nak episodes,
// backpressure, seq wrap with Nak priority, and reset during a handshake.
module tb_pcie_dll_acknak_scheduler;
  import pcie_dll_acknak_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        evt_valid;
  logic        evt_nak;
  logic [11:0] evt_seq;
  logic        nak_scheduled;
  logic        ack_pending;

  int n_cmp = 0;
  int n_mis = 0;
  int n_acc_ack = 0;
  int n_acc_nak = 0;
  logic [47:0] last_acc = '0;

  pcie_dll_acknak_scheduler_if dllp_if ();

  pcie_dll_acknak_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .evt_valid_i     (evt_valid),
    .evt_nak_i       (evt_nak),
    .evt_seq_i       (evt_seq),
    .tx              (dllp_if),
    .nak_scheduled_o (nak_scheduled),
    .ack_pending_o   (ack_pending)
  );

  always #5 clk = ~clk;

  // Accepted-DLLP monitor
  always @(posedge clk) begin
    if (!rst && dllp_if.dllp_valid_o && dllp_if.dllp_ready_i) begin
      last_acc = dllp_if.dllp_o;
      if (dllp_if.dllp_o.ack_or_nak == DLLP_NAK) n_acc_nak++;
      else                                       n_acc_ack++;
    end
  end

`ifdef DLLP_CRC16_EN
  function automatic logic [15:0] ref_crc(input logic [31:0] d);
    logic [15:0] c;
    logic [7:0]  byt;
    c = 16'hFFFF;
    for (int b = 3; b >= 0; b--) begin
      byt = d[b*8 +: 8];
      c   = c ^ {byt, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h100B) : (c << 1);
    end
    return ~c;
  endfunction
`endif

  function automatic logic [47:0] exp_pkt(input logic [7:0] t, input logic [11:0] s);
    logic [15:0] crc;
`ifdef DLLP_CRC16_EN
    crc = ref_crc({t, 12'h000, s});
`else
    crc = 16'h0000;
`endif
    return {t, 12'h000, s, crc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic nak, input logic [11:0] seq);
    evt_valid = 1'b1;
    evt_nak   = nak;
    evt_seq   = seq;
    @(negedge clk);
    evt_valid = 1'b0;
    evt_nak   = 1'b0;
    evt_seq   = 12'h000;
  endtask

  task automatic wait_valid(input string tag, input int max, output int cyc);
    cyc = 0;
    while (!dllp_if.dllp_valid_o && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    if (!dllp_if.dllp_valid_o) chk({tag, "_timeout"}, 64'(dllp_if.dllp_valid_o), 64'(1));
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    evt_valid = 1'b0;
    evt_nak   = 1'b0;
    evt_seq   = 12'h000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int base_a;
    int base_n;

    rst                  = 1'b1;
    evt_valid            = 1'b0;
    evt_nak              = 1'b0;
    evt_seq              = 12'h000;
    dllp_if.dllp_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid",   64'(dllp_if.dllp_valid_o), 64'(0));
    chk("rst_dllp",    64'(dllp_if.dllp_o),       64'(0));
    chk("rst_naksch",  64'(nak_scheduled),        64'(0));
    chk("rst_pending", 64'(ack_pending),          64'(0));

    // Coalesce: four good TLPs force an Ack
    do_reset();
    dllp_if.dllp_ready_i = 1'b1;
    base_a = n_acc_ack;
    for (int i = 0; i < 4; i++) send(1'b0, 12'(i));
    chk("coal_not_yet", 64'(dllp_if.dllp_valid_o), 64'(0));
    @(negedge clk);
    chk("coal_valid", 64'(dllp_if.dllp_valid_o), 64'(1));
    chk("coal_pkt",   64'(dllp_if.dllp_o),       64'(exp_pkt(DLLP_ACK, 12'h003)));
    @(negedge clk);
    chk("coal_done",    64'(dllp_if.dllp_valid_o), 64'(0));
    chk("coal_pending", 64'(ack_pending),          64'(0));
    chk("coal_count",   64'(n_acc_ack - base_a),   64'(1));

    // Latency: a lone good TLP is acked once the timer reaches 255
    do_reset();
    send(1'b0, 12'h005);
    wait_valid("lat", 400, cyc);
    chk("lat_cycles", 64'(cyc),             64'(256));
    chk("lat_pkt",    64'(dllp_if.dllp_o),  64'(exp_pkt(DLLP_ACK, 12'h005)));
    @(negedge clk);
    chk("lat_pending", 64'(ack_pending),    64'(0));

    // Nak episode: three bad TLPs give a single Nak
    do_reset();
    base_n = n_acc_nak;
    send(1'b0, 12'h007);
    repeat (3) send(1'b1, 12'h000);
    repeat (4) @(negedge clk);
    chk("nak_once",    64'(n_acc_nak - base_n), 64'(1));
    chk("nak_pkt",     64'(last_acc),           64'(exp_pkt(DLLP_NAK, 12'h007)));
    chk("nak_sched",   64'(nak_scheduled),      64'(1));
    send(1'b0, 12'h008);
    chk("nak_cleared", 64'(nak_scheduled),      64'(0));
    send(1'b1, 12'h000);
    wait_valid("nak2", 10, cyc);
    chk("nak2_pkt",    64'(dllp_if.dllp_o),     64'(exp_pkt(DLLP_NAK, 12'h008)));
    @(negedge clk);
    chk("nak2_count",  64'(n_acc_nak - base_n), 64'(2));

    // Backpressure: held Ack stays stable while a newer TLP arrives
    do_reset();
    dllp_if.dllp_ready_i = 1'b0;
    send(1'b0, 12'hFFF);
    for (int i = 0; i < 3; i++) send(1'b0, 12'(i));
    @(negedge clk);
    chk("bp_valid", 64'(dllp_if.dllp_valid_o), 64'(1));
    send(1'b0, 12'h003);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 64'({dllp_if.dllp_valid_o, dllp_if.dllp_o}),
          64'({1'b1, exp_pkt(DLLP_ACK, 12'h002)}));
      @(negedge clk);
    end
    dllp_if.dllp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_accepted", 64'(dllp_if.dllp_valid_o), 64'(0));
    chk("bp_pending",  64'(ack_pending),          64'(1));
    wait_valid("bp2", 400, cyc);
    chk("bp2_cycles",  64'(cyc),                  64'(256));
    chk("bp2_pkt",     64'(dllp_if.dllp_o),       64'(exp_pkt(DLLP_ACK, 12'h003)));

    // Wrap and priority: Nak for seq 0x000 goes before the pending Ack
    do_reset();
    base_a = n_acc_ack;
    base_n = n_acc_nak;
    send(1'b0, 12'hFFE);
    send(1'b0, 12'hFFF);
    send(1'b0, 12'h000);
    send(1'b1, 12'h000);
    @(negedge clk);
    chk("wrap_nak_valid", 64'(dllp_if.dllp_valid_o), 64'(1));
    chk("wrap_nak_pkt",   64'(dllp_if.dllp_o),       64'(exp_pkt(DLLP_NAK, 12'h000)));
    chk("wrap_pending",   64'(ack_pending),          64'(1));
    send(1'b0, 12'h001);
    chk("wrap_naksch",    64'(nak_scheduled),        64'(0));
    chk("wrap_no_ack",    64'(n_acc_ack - base_a),   64'(0));
    chk("wrap_nak_cnt",   64'(n_acc_nak - base_n),   64'(1));
    wait_valid("wrap_ack", 10, cyc);
    chk("wrap_ack_pkt",   64'(dllp_if.dllp_o),       64'(exp_pkt(DLLP_ACK, 12'h001)));

    // Reset while a Nak is held: valid drops at once, no replay afterwards
    do_reset();
    dllp_if.dllp_ready_i = 1'b0;
    send(1'b0, 12'h009);
    send(1'b1, 12'h000);
    @(negedge clk);
    chk("rh_held",    64'(dllp_if.dllp_o), 64'(exp_pkt(DLLP_NAK, 12'h009)));
    #2 rst = 1'b1;
    #1;
    chk("rh_valid",   64'(dllp_if.dllp_valid_o), 64'(0));
    chk("rh_dllp",    64'(dllp_if.dllp_o),       64'(0));
    chk("rh_naksch",  64'(nak_scheduled),        64'(0));
    chk("rh_pending", 64'(ack_pending),          64'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dllp_if.dllp_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rh_no_replay", 64'(dllp_if.dllp_valid_o), 64'(0));
    send(1'b1, 12'h000);
    wait_valid("rh_nak", 10, cyc);
    chk("rh_nak_pkt", 64'(dllp_if.dllp_o), 64'(exp_pkt(DLLP_NAK, 12'hFFF)));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pcie_dll_acknak_scheduler.md
Name: pcie_dll_acknak_scheduler

Overview:
Sits downstream of the DLL RX stage, between RX and the DLL TX arbiter toward the Physical Layer. Consumes per-TLP good/bad events from DLL RX and generates paced Ack/Nak DLLPs. Coalesces Acks under a latency timer and count threshold. Schedules at most one Nak per error episode and holds each DLLP under a valid/ready handshake until TX accepts it.

Parameters:
ACK_LATENCY, 16'd255, idle cycles after the first pending Ack before an Ack is forced
ACK_COALESCE, 8'd4, number of pending good TLPs that forces an immediate Ack
TIMER_W, 16, width of the Ack latency timer

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
evt_valid_i  input  1  one-cycle event from DLL RX per received TLP
evt_nak_i  input  1  1 = bad TLP (CRC error or unexpected seq), 0 = good TLP
evt_seq_i  input  12  sequence number of the good TLP (ignored when evt_nak_i=1)
dllp_valid_o  output  1  DLLP available to TX arbiter
dllp_o  output  PCIe_DLLP_PACKET_SIZE  PCIe_PKG::dllp_packet (ack_or_nak, seq_num, crc16)
dllp_ready_i  input  1  TX arbiter accepts DLLP
nak_scheduled_o  output  1  Nak episode active
ack_pending_o  output  1  unacknowledged good TLPs outstanding

Behaviour:
- Single clock; async active-high reset. Reset values:
  - dllp_valid_o=0, dllp_o=0, nak_scheduled_o=0, ack_pending_o=0
  - internal last_seq=12'hFFF (value equals NEXT_RCV_SEQ-1 with expected seq 0), pend_cnt=0, timer=0, state=IDLE
- Good event:
  - last_seq<=evt_seq_i; ack_pending<=1; pend_cnt<=sat(pend_cnt+1).
  - Timer starts on the first pending event; it is not restarted by later events.
  - Clears nak_scheduled.
- Bad event:
  - If nak_scheduled=0, set nak_scheduled and nak_req.
  - If nak_scheduled=1, ignore (no duplicate Nak).
- Timer:
  - Increments each cycle while ack_pending=1 and state=IDLE, saturating at all-ones.
  - Cleared whenever an Ack is accepted.
- States:
  - IDLE: if nak_req -> SEND_NAK. Else if ack_pending and (timer>=ACK_LATENCY or pend_cnt>=ACK_COALESCE) -> SEND_ACK.
  - SEND_NAK: dllp_valid_o=1, ack_or_nak=8'h10, seq_num=last_seq captured on entry. On dllp_ready_i: clear nak_req, -> IDLE.
  - SEND_ACK: dllp_valid_o=1, ack_or_nak=8'h00, seq_num=last_seq captured on entry. On dllp_ready_i: clear ack_pending/pend_cnt/timer, -> IDLE.
- Registered outputs:
  - Entry into SEND_* takes 1 cycle after the trigger condition.
  - dllp_o is stable while valid=1 and ready=0; valid is never withdrawn.
- Priority: Nak beats Ack in IDLE. A Nak arriving while an Ack is held does not preempt it; the Nak is sent next.
- Simultaneous good event and Ack acceptance:
  - The new event wins: ack_pending=1, pend_cnt=1, timer restarts at 0.
  - last_seq updates to the new value.
- Nak acceptance in the same cycle as a good event: nak_scheduled clears; the Ack path proceeds normally.
- Seq arithmetic is modulo 4096. 12'hFFF is a valid wrapped value.
- Reset mid-handshake: valid drops immediately, all state is cleared, and no DLLP is replayed.

Optional Feature:
DLLP_CRC16_EN
- Defined: dllp_o.crc16 = CRC-16 (poly 16'h100B, init 16'hFFFF, inverted output) over the 4 DLLP bytes. Computed combinationally from the captured fields and registered with them.
- Undefined: crc16 field = 16'h0000; TX arbiter appends the CRC.

Decomposition:
- Add to PCIe_PKG:
  - typedef dllp_packet (ack_or_nak[7:0], reserved, seq_num[11:0], crc16[15:0])
  - localparams DLLP_ACK=8'h00, DLLP_NAK=8'h10
  - PCIe_DLLP_PACKET_SIZE
  - enum acknak_state_e {IDLE, SEND_ACK, SEND_NAK}
- One sub-module, pcie_dllp_crc16: combinational, 32-bit data in, 16-bit CRC out; instantiated only under DLLP_CRC16_EN.

Test Plan:
- Coalesce: good events seq 0,1,2,3 on consecutive cycles, ready=1 -> one Ack with seq_num=3 two cycles after the 4th event; ack_pending_o then 0.
- Latency: a single good event seq 5, no further events -> Ack seq_num=5 asserted at timer=255, i.e. 256-257 cycles after the event.
- Nak episode: good seq 7, then 3 bad events -> exactly one Nak with seq_num=7. Then good seq 8 -> nak_scheduled_o=0; a later bad event yields a new Nak seq_num=8.
- Backpressure: Ack seq 2 held with ready=0 for 10 cycles while good seq 3 arrives -> dllp_o stays Ack/2. After acceptance, ack_pending_o=1 and a later Ack carries seq 3.
- Wrap and priority: good seq 12'hFFE, 12'hFFF, 12'h000, then a bad event in the same IDLE window -> Nak seq_num=12'h000 sent before the Ack.
- Reset: assert rst while dllp_valid_o=1 -> valid=0 asynchronously. After release, the first bad event gives Nak seq_num=12'hFFF. With DLLP_CRC16_EN, the crc16 field matches the reference model.
